// File: rtl/l2_victim_buffer.sv
`default_nettype none
// ============================================================================
// Module   : l2_victim_buffer
// Purpose  : Single-entry write-back (victim) buffer placed between the L2
//            cache's physical-memory port and the cacheline adaptor. A dirty
//            256-bit line evicted by L2 is accepted and acknowledged at once,
//            so the refill read that follows reaches memory first. The held
//            line is drained when the memory port is otherwise idle. Reads
//            that hit the held line are answered from the buffer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1    system clock
//   rst           in   1    synchronous active-high reset
//   mem_address   in   32   L2-side line address, bits [4:0] ignored
//   mem_read      in   1    L2 read request, held until mem_resp
//   mem_write     in   1    L2 write-back request, held until mem_resp
//   mem_wdata     in   256  L2 write-back line
//   mem_rdata     out  256  line returned to L2, valid while mem_resp=1
//   mem_resp      out  1    one-cycle completion pulse to L2
//   pmem_address  out  32   memory-side line address, bits [4:0] = 0
//   pmem_read     out  1    read request to adaptor, held until pmem_resp
//   pmem_write    out  1    write request to adaptor, held until pmem_resp
//   pmem_wdata    out  256  buffered line being drained
//   pmem_rdata    in   256  line from adaptor, valid when pmem_resp=1
//   pmem_resp     in   1    adaptor completion pulse
// ============================================================================
module l2_victim_buffer (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  mem_address,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [255:0] mem_wdata,
   output logic [255:0] mem_rdata,
   output logic         mem_resp,
   output logic [31:0]  pmem_address,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [255:0] pmem_wdata,
   input  logic [255:0] pmem_rdata,
   input  logic         pmem_resp
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_READ_MEM  = 2'd1,
      ST_WRITE_MEM = 2'd2,
      ST_RESP      = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_next_state;

   // Buffer entry
   logic           r_vb_valid;
   logic [26:0]    r_vb_tag;
   logic [255:0]   r_vb_data;

   // Registered outputs
   logic [255:0]   r_mem_rdata;
   logic [31:0]    r_pmem_address;
   logic [255:0]   r_pmem_wdata;

   // Per-cycle actions decoded by the next-state logic
   logic           w_hit;
   logic           w_capture;      // store L2 write into the entry
   logic           w_load_hit;     // answer L2 read from the entry
   logic           w_start_read;   // launch a memory read for L2
   logic           w_start_drain;  // launch a memory write of the entry
   logic           w_latch_rd;     // memory read data arrived
   logic           w_drain_done;   // memory accepted the drained line

   // Line offset bits carry no meaning for a line-granular buffer.
   logic           w_unused_addr_bits;
   assign w_unused_addr_bits = ^mem_address[4:0];

   assign w_hit = r_vb_valid && (r_vb_tag == mem_address[31:5]);

   // -------------------------------------------------------------------------
   // Next-state and action decode
   // -------------------------------------------------------------------------
   always_comb begin
      w_next_state  = r_state;
      w_capture     = 1'b0;
      w_load_hit    = 1'b0;
      w_start_read  = 1'b0;
      w_start_drain = 1'b0;
      w_latch_rd    = 1'b0;
      w_drain_done  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // Writes are checked first so an illegal read+write resolves as
            // a write. A write that would displace a different line must
            // first push the old line out; it is taken on the return here.
            if (mem_write && (!r_vb_valid || w_hit)) begin
               w_capture    = 1'b1;
               w_next_state = ST_RESP;
            end else if (mem_write) begin
               w_start_drain = 1'b1;
               w_next_state  = ST_WRITE_MEM;
            end else if (mem_read && w_hit) begin
               w_load_hit   = 1'b1;
               w_next_state = ST_RESP;
            end else if (mem_read) begin
               // Refill goes ahead of the pending drain; the entry stays.
               w_start_read = 1'b1;
               w_next_state = ST_READ_MEM;
            end else if (r_vb_valid) begin
               w_start_drain = 1'b1;
               w_next_state  = ST_WRITE_MEM;
            end
         end

         ST_READ_MEM: begin
            if (pmem_resp) begin
               w_latch_rd   = 1'b1;
               w_next_state = ST_RESP;
            end
         end

         ST_WRITE_MEM: begin
            // A drain is never abandoned; L2 requests wait in IDLE.
            if (pmem_resp) begin
               w_drain_done = 1'b1;
               w_next_state = ST_IDLE;
            end
         end

         ST_RESP: begin
            w_next_state = ST_IDLE;
         end

         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State, buffer entry and output registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_vb_valid     <= 1'b0;
         r_vb_tag       <= '0;
         r_vb_data      <= '0;
         r_mem_rdata    <= '0;
         r_pmem_address <= '0;
         r_pmem_wdata   <= '0;
      end else begin
         r_state <= w_next_state;

         if (w_capture) begin
            r_vb_valid <= 1'b1;
            r_vb_tag   <= mem_address[31:5];
            r_vb_data  <= mem_wdata;
         end else if (w_drain_done) begin
            r_vb_valid <= 1'b0;
         end

         // The memory-side address/data are set up on entry to the memory
         // state so the adaptor sees only registered values.
         if (w_start_drain) begin
            r_pmem_address <= {r_vb_tag, 5'b0};
            r_pmem_wdata   <= r_vb_data;
         end else if (w_start_read) begin
            r_pmem_address <= {mem_address[31:5], 5'b0};
         end

         if (w_load_hit) begin
            r_mem_rdata <= r_vb_data;
         end else if (w_latch_rd) begin
            r_mem_rdata <= pmem_rdata;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs (state or register driven only)
   // -------------------------------------------------------------------------
   assign mem_rdata    = r_mem_rdata;
   assign mem_resp     = (r_state == ST_RESP);
   assign pmem_read    = (r_state == ST_READ_MEM);
   assign pmem_write   = (r_state == ST_WRITE_MEM);
   assign pmem_address = r_pmem_address;
   assign pmem_wdata   = r_pmem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_l2_victim_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_victim_buffer
// Purpose  : Directed self-checking bench for l2_victim_buffer. A simple
//            adaptor model answers memory requests after a fixed latency and
//            logs completed transactions in order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_victim_buffer;

   localparam int LAT = 3;

   logic         clk;
   logic         rst;
   logic [31:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata;
   logic         mem_resp;
   logic [31:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int last_resp_cyc = 0;

   int unsigned  txn_kind[$];   // 0 = read, 1 = write
   logic [31:0]  txn_addr[$];
   logic [255:0] txn_data[$];

   l2_victim_buffer dut (
      .clk          (clk),
      .rst          (rst),
      .mem_address  (mem_address),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_resp     (mem_resp),
      .pmem_address (pmem_address),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [255:0] line_of(input logic [31:0] a);
      return {8{a ^ 32'h5A5A_0000}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      txn_kind.delete();
      txn_addr.delete();
      txn_data.delete();
   endtask

   task automatic wait_txns(input int n);
      for (int i = 0; i < 60 && txn_kind.size() < n; i++) tick();
   endtask

   task automatic wait_mem_resp();
      for (int i = 0; i < 60 && mem_resp !== 1'b1; i++) tick();
   endtask

   // Adaptor model: acts 2 time units after each edge, answers the LAT-th
   // cycle of a held request with a one-cycle pmem_resp.
   initial begin : adaptor
      int busy;
      busy       = 0;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         pmem_resp = 1'b0;
         if (!rst && (pmem_read || pmem_write)) begin
            busy++;
            if (busy >= LAT) begin
               pmem_resp     = 1'b1;
               last_resp_cyc = cyc;
               busy          = 0;
               txn_addr.push_back(pmem_address);
               if (pmem_write) begin
                  txn_kind.push_back(1);
                  txn_data.push_back(pmem_wdata);
               end else begin
                  txn_kind.push_back(0);
                  txn_data.push_back('0);
                  pmem_rdata = line_of(pmem_address);
               end
            end
         end else begin
            busy = 0;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   // -------------------------------------------------------------------------
   task automatic test_reset();
      int seen;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++;
      if ({mem_resp, pmem_read, pmem_write} !== 3'b000)
         $display("FAIL reset_ctrl: got %b want 000", {mem_resp, pmem_read, pmem_write});
      else n_pass++;
      n_checks++;
      if (mem_rdata !== '0) $display("FAIL reset_rdata: got %h want 0", mem_rdata);
      else n_pass++;
      n_checks++;
      if (pmem_address !== 32'h0 || pmem_wdata !== '0)
         $display("FAIL reset_pmem: got addr %h wdata %h want 0", pmem_address, pmem_wdata);
      else n_pass++;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (pmem_read || pmem_write || mem_resp) seen++;
      end
      n_checks++;
      if (seen != 0) $display("FAIL reset_idle: got %0d active cycles want 0", seen);
      else n_pass++;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_write_drain();
      logic [255:0] d;
      d = {32{8'hA5}};
      clear_log();
      mem_address = 32'h0000_1000;
      mem_wdata   = d;
      mem_write   = 1'b1;                     // cycle T
      n_checks++;
      if (mem_resp !== 1'b0) $display("FAIL wd_resp_T: got %b want 0", mem_resp);
      else n_pass++;
      tick();                                 // T+1
      n_checks++;
      if (mem_resp !== 1'b1) $display("FAIL wd_resp_T1: got %b want 1", mem_resp);
      else n_pass++;
      mem_write = 1'b0;
      tick();                                 // T+2
      n_checks++;
      if (pmem_write !== 1'b0 || mem_resp !== 1'b0)
         $display("FAIL wd_T2: got pw %b resp %b want 0 0", pmem_write, mem_resp);
      else n_pass++;
      tick();                                 // T+3
      n_checks++;
      if (pmem_write !== 1'b1 || pmem_address !== 32'h1000 || pmem_wdata !== d)
         $display("FAIL wd_drain: got pw %b addr %h data %h want 1 1000 %h",
                  pmem_write, pmem_address, pmem_wdata, d);
      else n_pass++;
      wait_txns(1);
      repeat (12) tick();
      n_checks++;
      if (txn_kind.size() != 1 || txn_kind[0] != 1)
         $display("FAIL wd_single: got %0d txns want 1 write", txn_kind.size());
      else n_pass++;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_read_miss_after_write();
      logic [255:0] d;
      d = {32{8'h3C}};
      clear_log();
      repeat (2) tick();
      mem_address = 32'h0000_1000;
      mem_wdata   = d;
      mem_write   = 1'b1;                     // T
      tick();                                 // T+1
      n_checks++;
      if (mem_resp !== 1'b1) $display("FAIL rm_wr_resp: got %b want 1", mem_resp);
      else n_pass++;
      mem_write = 1'b0;
      tick();                                 // T+2
      mem_address = 32'h0000_2000;
      mem_read    = 1'b1;
      tick();                                 // T+3
      n_checks++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h2000)
         $display("FAIL rm_issue: got pr %b pw %b addr %h want 1 0 2000",
                  pmem_read, pmem_write, pmem_address);
      else n_pass++;
      wait_mem_resp();
      n_checks++;
      if (mem_resp !== 1'b1 || cyc != last_resp_cyc + 1)
         $display("FAIL rm_resp_time: got resp %b cyc %0d want 1 cyc %0d",
                  mem_resp, cyc, last_resp_cyc + 1);
      else n_pass++;
      n_checks++;
      if (mem_rdata !== line_of(32'h2000))
         $display("FAIL rm_rdata: got %h want %h", mem_rdata, line_of(32'h2000));
      else n_pass++;
      mem_read = 1'b0;
      wait_txns(2);
      n_checks++;
      if (txn_kind.size() != 2 || txn_kind[0] != 0 || txn_kind[1] != 1 ||
          txn_addr[1] !== 32'h1000 || txn_data[1] !== d)
         $display("FAIL rm_order: got %0d txns want read then write of 1000", txn_kind.size());
      else n_pass++;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_read_hit();
      logic [255:0] d;
      d = {32{8'h5E}};
      clear_log();
      repeat (2) tick();
      mem_address = 32'h0000_1000;
      mem_wdata   = d;
      mem_write   = 1'b1;                     // T
      tick();                                 // T+1
      mem_write = 1'b0;
      tick();                                 // T+2
      mem_address = 32'h0000_1004;
      mem_read    = 1'b1;
      tick();                                 // T+3
      n_checks++;
      if (mem_resp !== 1'b1 || mem_rdata !== d || pmem_read !== 1'b0)
         $display("FAIL rh_hit: got resp %b pr %b rdata %h want 1 0 %h",
                  mem_resp, pmem_read, mem_rdata, d);
      else n_pass++;
      mem_read = 1'b0;
      wait_txns(1);
      repeat (5) tick();
      n_checks++;
      if (txn_kind.size() != 1 || txn_kind[0] != 1 || txn_addr[0] !== 32'h1000)
         $display("FAIL rh_no_read: got %0d txns want 1 write of 1000", txn_kind.size());
      else n_pass++;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_write_merge();
      logic [255:0] d1, d2;
      d1 = {32{8'h01}};
      d2 = {32{8'h02}};
      clear_log();
      repeat (2) tick();
      mem_address = 32'h0000_3000;
      mem_wdata   = d1;
      mem_write   = 1'b1;                     // T
      tick();                                 // T+1
      mem_write = 1'b0;
      tick();                                 // T+2
      mem_wdata = d2;
      mem_write = 1'b1;
      tick();                                 // T+3
      n_checks++;
      if (mem_resp !== 1'b1 || pmem_write !== 1'b0)
         $display("FAIL wm_resp: got resp %b pw %b want 1 0", mem_resp, pmem_write);
      else n_pass++;
      mem_write = 1'b0;
      wait_txns(1);
      repeat (12) tick();
      n_checks++;
      if (txn_kind.size() != 1 || txn_data[0] !== d2 || txn_addr[0] !== 32'h3000)
         $display("FAIL wm_merge: got %0d txns want one write of 3000 with D2", txn_kind.size());
      else n_pass++;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_read_during_drain();
      logic [255:0] d;
      d = {32{8'hC3}};
      clear_log();
      repeat (2) tick();
      mem_address = 32'h0000_6000;
      mem_wdata   = d;
      mem_write   = 1'b1;                     // T
      tick();                                 // T+1
      mem_write = 1'b0;
      tick();                                 // T+2 idle with entry valid
      tick();                                 // T+3 drain under way
      n_checks++;
      if (pmem_write !== 1'b1 || pmem_address !== 32'h6000)
         $display("FAIL dr_start: got pw %b addr %h want 1 6000", pmem_write, pmem_address);
      else n_pass++;
      mem_read = 1'b1;
      wait_mem_resp();
      n_checks++;
      if (mem_resp !== 1'b1 || mem_rdata !== line_of(32'h6000))
         $display("FAIL dr_read: got resp %b rdata %h want 1 %h",
                  mem_resp, mem_rdata, line_of(32'h6000));
      else n_pass++;
      mem_read = 1'b0;
      n_checks++;
      if (txn_kind.size() != 2 || txn_kind[0] != 1 || txn_kind[1] != 0)
         $display("FAIL dr_order: got %0d txns want write then read", txn_kind.size());
      else n_pass++;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_back_to_back();
      logic [255:0] da, db;
      int seen, p;
      da = {32{8'hAA}};
      db = {32{8'hBB}};
      clear_log();
      repeat (2) tick();
      mem_address = 32'h0000_4000;
      mem_wdata   = da;
      mem_write   = 1'b1;                     // T
      tick();                                 // T+1
      mem_write = 1'b0;
      tick();                                 // T+2
      mem_address = 32'h0000_5000;
      mem_wdata   = db;
      mem_write   = 1'b1;
      tick();                                 // T+3
      n_checks++;
      if (pmem_write !== 1'b1 || pmem_address !== 32'h4000 || pmem_wdata !== da)
         $display("FAIL bb_drain_a: got pw %b addr %h want 1 4000", pmem_write, pmem_address);
      else n_pass++;
      wait_mem_resp();
      p = last_resp_cyc;
      n_checks++;
      if (mem_resp !== 1'b1 || cyc != p + 2)
         $display("FAIL bb_resp_b: got resp %b cyc %0d want 1 cyc %0d", mem_resp, cyc, p + 2);
      else n_pass++;
      mem_write = 1'b0;
      for (int i = 0; i < 10 && pmem_write !== 1'b1; i++) tick();
      n_checks++;
      if (pmem_write !== 1'b1 || pmem_address !== 32'h5000 || pmem_wdata !== db)
         $display("FAIL bb_drain_b: got pw %b addr %h want 1 5000", pmem_write, pmem_address);
      else n_pass++;
      rst = 1'b1;                             // mid-drain reset
      tick();
      rst = 1'b0;
      n_checks++;
      if (pmem_write !== 1'b0 || pmem_address !== 32'h0 || mem_rdata !== '0)
         $display("FAIL bb_rst: got pw %b addr %h rdata %h want 0 0 0",
                  pmem_write, pmem_address, mem_rdata);
      else n_pass++;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (pmem_write) seen++;
      end
      n_checks++;
      if (seen != 0) $display("FAIL bb_empty: got %0d drain cycles want 0", seen);
      else n_pass++;
      mem_address = 32'h0000_5000;
      mem_read    = 1'b1;
      wait_mem_resp();
      n_checks++;
      if (mem_resp !== 1'b1 || mem_rdata !== line_of(32'h5000))
         $display("FAIL bb_miss: got resp %b rdata %h want 1 %h",
                  mem_resp, mem_rdata, line_of(32'h5000));
      else n_pass++;
      mem_read = 1'b0;
      tick();
   endtask

   // -------------------------------------------------------------------------
   initial begin : main
      rst         = 1'b1;
      mem_address = '0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_wdata   = '0;
      test_reset();
      test_write_drain();
      test_read_miss_after_write();
      test_read_hit();
      test_write_merge();
      test_read_during_drain();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/l2_victim_buffer.md
# l2_victim_buffer

Single-entry write-back (victim) buffer between the L2 cache's physical-memory port and the cacheline adaptor. A dirty 256-bit line evicted by L2 is accepted and acknowledged immediately, so the L2 refill read reaches memory first; the buffered line is drained to memory when the downstream port is otherwise idle. Reads that hit the buffered line are served from the buffer without a memory access.

## Interface
Parameters: none. The line size is fixed at 256 bits and addresses are 32-bit, line-aligned on bits [4:0].

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous, active-high
- mem_address  in  32  L2-side line address; bits [4:0] ignored
- mem_read  in  1  L2 read request; held until mem_resp
- mem_write  in  1  L2 write-back request; held until mem_resp
- mem_wdata  in  256  L2 write-back line
- mem_rdata  out  256  line returned to L2; valid while mem_resp=1
- mem_resp  out  1  one-cycle completion pulse to L2
- pmem_address  out  32  memory-side line address, bits [4:0] = 0
- pmem_read  out  1  read request to adaptor; held until pmem_resp
- pmem_write  out  1  write request to adaptor; held until pmem_resp
- pmem_wdata  out  256  buffered line being drained
- pmem_rdata  in  256  line from adaptor; valid when pmem_resp=1
- pmem_resp  in  1  adaptor completion pulse

## Operation
- Storage: `vb_valid`, `vb_tag[26:0]` (address [31:5]) and `vb_data[255:0]`. A hit is `vb_valid && vb_tag == mem_address[31:5]`.
- States: IDLE, READ_MEM, WRITE_MEM, RESP.
- IDLE priority order, evaluated each cycle:
  1. mem_write with buffer empty, or buffer hit: capture the tag and data (a hit overwrites the entry in place), set vb_valid, go to RESP.
  2. mem_write with the buffer valid and no hit: go to WRITE_MEM to drain. The pending write is captured on the return to IDLE.
  3. mem_read with a hit: load mem_rdata from vb_data, go to RESP.
  4. mem_read with no hit: go to READ_MEM. The buffer stays valid; its drain is deferred.
  5. No request and vb_valid: go to WRITE_MEM (opportunistic drain).
  6. Otherwise stay in IDLE.
- READ_MEM: pmem_read=1, pmem_address={mem_address[31:5],5'b0}. On pmem_resp, latch pmem_rdata into mem_rdata and go to RESP.
- WRITE_MEM: pmem_write=1, pmem_address={vb_tag,5'b0}, pmem_wdata=vb_data. On pmem_resp, clear vb_valid and go to IDLE.
  - Once entered, a drain always completes. L2 requests arriving during a drain wait in IDLE.
- RESP: mem_resp=1 for exactly one cycle, then go to IDLE. L2 requests are not sampled in RESP.
- mem_read and mem_write asserted together is illegal; if it occurs, write wins.
- pmem_read and pmem_write are never high together.
- mem_rdata holds its last value outside RESP.

## Timing
- Reset (rst=1 at a clock edge):
  - state=IDLE, vb_valid=0.
  - mem_resp, pmem_read, pmem_write = 0; mem_rdata, pmem_address, pmem_wdata = 0.
  - Reset mid-drain or mid-read drops the request on the next cycle; buffered data is discarded.
- All outputs are driven from registers or state (Moore); there are no combinational paths from input to output.
- Buffered write, or read hit, accepted in IDLE at cycle T: mem_resp=1 in cycle T+1.
- Read miss seen at T:
  - pmem_read rises at T+1.
  - pmem_resp arrives at cycle P; mem_resp and valid mem_rdata follow at P+1.
- Write with a full buffer and no hit at T:
  - pmem_write rises at T+1; pmem_resp arrives at P.
  - The buffer is empty and state is IDLE at P+1; the write is captured there.
  - mem_resp at P+2.
- Opportunistic drain starts the cycle after an idle cycle with vb_valid=1.
  - A read arriving in that cycle or later waits for the drain to finish, then sees a miss.
- Back-to-back: L2 may issue a new request in the cycle after mem_resp; it is accepted in that IDLE cycle.

## Test plan
- Reset, then idle: all outputs are 0 and no pmem request appears for 20 cycles.
- Write-back A=0x0000_1000, D=0xA5…A5 at T: mem_resp at T+1. With no further requests, pmem_write rises at T+3 with pmem_address=0x1000 and pmem_wdata=D. vb_valid=0 after pmem_resp.
- Write A=0x1000 then immediately read B=0x2000 (miss):
  - pmem_read is issued first with address 0x2000; mem_rdata equals the adaptor line at mem_resp.
  - The drain of 0x1000 follows.
- Write A=0x1000 (D1), then read 0x1004: no pmem activity; mem_rdata=D1 one cycle after the request.
- Write A (D1), then write A (D2) before the drain starts: one pmem_write only, carrying D2.
- Write A, then write B while the buffer is still full: A drains first (pmem_write addr=A), then B is accepted with mem_resp two cycles after A's pmem_resp. Assert rst mid-drain and check that pmem_write is 0 the next cycle and vb_valid=0.
